// File: rtl/mem_access_if.sv
// Data-bus bundle between the MEM stage (master) and memory (slave).
// Word-aligned req/ack handshake with byte enables.
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: issues aligned load/store requests on the data bus, stalls until ack
// or timeout, and aligns/extends load data for writeback.
module mem_access #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ctrl_mem_MemRead_i,
    input  logic         ctrl_mem_MemWrite_i,
    input  logic [2:0]   ctrl_mem_funct3_i,
    input  logic         ctrl_wb_RegWrite_i,
    input  logic         ctrl_wb_Mem2Reg_i,
    input  logic [31:0]  alu_result_i,
    input  logic [31:0]  store_data_i,
    input  logic [4:0]   write_addr_i,
    output logic         ctrl_wb_RegWrite_o,
    output logic         ctrl_wb_Mem2Reg_o,
    output logic [31:0]  alu_result_o,
    output logic [4:0]   write_addr_o,
    output logic [31:0]  mem_read_data_o,
    output logic         stall_o,
    output logic         fault_o,
    output logic         bus_err_o,
    mem_access_if.master dbus
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [7:0] LastCnt = 8'(ACK_TIMEOUT - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        err_q;
    logic [31:0] result_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        acc;
    logic        we_d;
    logic        illegal;
    logic        misaligned;
    logic        fault;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign acc  = ctrl_mem_MemRead_i | ctrl_mem_MemWrite_i;
    // A simultaneous read and write is treated as a load.
    assign we_d = ctrl_mem_MemWrite_i & ~ctrl_mem_MemRead_i;

    assign illegal    = (ctrl_mem_funct3_i == 3'b011) | (ctrl_mem_funct3_i[2] & ctrl_mem_funct3_i[1]);
    assign misaligned = ((ctrl_mem_funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                        ((ctrl_mem_funct3_i[1:0] == 2'b10) & (alu_result_i[1:0] != 2'b00));
    assign fault      = illegal | misaligned;

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_data_i;
        case (ctrl_mem_funct3_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << alu_result_i[1:0];
                wdata_d = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << alu_result_i[1:0];
                wdata_d = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign byte_sel = dbus.rdata[{off_q, 3'b000} +: 8];
    assign half_sel = dbus.rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        load_data = dbus.rdata;
        case (funct3_q[1:0])
            2'b00:   load_data = {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            funct3_q <= '0;
            off_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (acc && !fault) begin
                        state_q  <= StBusy;
                        req_q    <= 1'b1;
                        we_q     <= we_d;
                        addr_q   <= {alu_result_i[31:2], 2'b00};
                        be_q     <= be_d;
                        wdata_q  <= wdata_d;
                        funct3_q <= ctrl_mem_funct3_i;
                        off_q    <= alu_result_i[1:0];
                        cnt_q    <= '0;
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q + 8'd1;
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (dbus.ack) begin
                        result_q <= we_q ? 32'h0 : load_data;
                        err_q    <= 1'b0;
                        req_q    <= 1'b0;
                        state_q  <= StDone;
                    end else if (cnt_q == LastCnt) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        req_q    <= 1'b0;
                        state_q  <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stall_o   = (state_q == StBusy) | ((state_q == StIdle) & acc & ~fault);
    assign fault_o   = (state_q == StIdle) & acc & fault;
    assign bus_err_o = (state_q == StDone) & err_q;

    assign ctrl_wb_RegWrite_o = ctrl_wb_RegWrite_i & ~fault_o & ~bus_err_o;
    assign ctrl_wb_Mem2Reg_o  = ctrl_wb_Mem2Reg_i;
    assign alu_result_o       = alu_result_i;
    assign write_addr_o       = write_addr_i;
    assign mem_read_data_o    = result_q;

    assign dbus.req   = req_q;
    assign dbus.we    = we_q;
    assign dbus.addr  = addr_q;
    assign dbus.wdata = wdata_q;
    assign dbus.be    = be_q;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, faults, timeout and reset during an access.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, reg_write, mem2reg;
    logic [2:0]  funct3;
    logic [31:0] alu, store_data;
    logic [4:0]  waddr;
    logic        regwrite_o, mem2reg_o, stall_o, fault_o, bus_err_o;
    logic [31:0] alu_o, rdata_o;
    logic [4:0]  waddr_o;

    int checks = 0;
    int errors = 0;

    int          ns, nr;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_be;
    logic        b_we;

    mem_access_if dbus ();

    mem_access #(.ACK_TIMEOUT(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ctrl_mem_MemRead_i  (mem_read),
        .ctrl_mem_MemWrite_i (mem_write),
        .ctrl_mem_funct3_i   (funct3),
        .ctrl_wb_RegWrite_i  (reg_write),
        .ctrl_wb_Mem2Reg_i   (mem2reg),
        .alu_result_i        (alu),
        .store_data_i        (store_data),
        .write_addr_i        (waddr),
        .ctrl_wb_RegWrite_o  (regwrite_o),
        .ctrl_wb_Mem2Reg_o   (mem2reg_o),
        .alu_result_o        (alu_o),
        .write_addr_o        (waddr_o),
        .mem_read_data_o     (rdata_o),
        .stall_o             (stall_o),
        .fault_o             (fault_o),
        .bus_err_o           (bus_err_o),
        .dbus                (dbus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one instruction, acks in BUSY cycle ack_at (0 = never), returns in the DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input int ack_at,
                          input logic [31:0] rdata);
        tick();
        mem_read = rd; mem_write = wr; funct3 = f3; alu = addr; store_data = sd;
        reg_write = 1'b1; mem2reg = rd;
        #1;
        ns = 0; nr = 0; b_addr = '0; b_wdata = '0; b_be = '0; b_we = 1'b0;
        for (int c = 0; c < 40 && stall_o; c++) begin
            ns++;
            if (dbus.req) begin
                nr++;
                if (nr == 1) begin
                    b_addr = dbus.addr; b_wdata = dbus.wdata; b_be = dbus.be; b_we = dbus.we;
                end
            end
            if (ack_at > 0 && ns == ack_at + 1) begin
                dbus.ack = 1'b1;
                dbus.rdata = rdata;
            end
            tick();
            dbus.ack = 1'b0;
        end
    endtask

    task automatic fault_case(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        tick();
        mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; alu = addr; reg_write = 1'b1;
        #1;
        check({tag, "_fault"}, 32'(fault_o), 32'h1);
        check({tag, "_regwrite"}, 32'(regwrite_o), 32'h0);
        check({tag, "_stall"}, 32'(stall_o), 32'h0);
        tick();
        check({tag, "_req"}, 32'(dbus.req), 32'h0);
        mem_read = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mem_read = 0; mem_write = 0; reg_write = 0; mem2reg = 0;
        funct3 = '0; alu = '0; store_data = '0; waddr = '0;
        dbus.ack = 1'b0; dbus.rdata = '0;
        #2;
        check("rst_req", 32'(dbus.req), 32'h0);
        check("rst_addr", dbus.addr, 32'h0);
        check("rst_be", 32'(dbus.be), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Non-memory instruction passes straight through
        alu = 32'hCAFE_F00D; waddr = 5'd7; reg_write = 1'b1;
        #1;
        check("pass_alu", alu_o, 32'hCAFE_F00D);
        check("pass_waddr", 32'(waddr_o), 32'd7);
        check("pass_regwrite", 32'(regwrite_o), 32'h1);
        check("pass_stall", 32'(stall_o), 32'h0);
        alu = 32'h0000_1234;
        #1;
        check("pass_alu2", alu_o, 32'h0000_1234);

        access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
        check("lw_stall", ns, 4);
        check("lw_req", nr, 3);
        check("lw_addr", b_addr, 32'h100);
        check("lw_be", 32'(b_be), 32'hF);
        check("lw_we", 32'(b_we), 32'h0);
        check("lw_data", rdata_o, 32'hDEAD_BEEF);
        check("lw_regwrite", 32'(regwrite_o), 32'h1);
        check("lw_done_stall", 32'(stall_o), 32'h0);
        check("lw_done_req", 32'(dbus.req), 32'h0);

        access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_7F01);
        check("lb_stall", ns, 2);
        check("lb_addr", b_addr, 32'h100);
        check("lb_be", 32'(b_be), 32'h8);
        check("lb_data", rdata_o, 32'hFFFF_FF80);
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_7F01);
        check("lbu_data", rdata_o, 32'h0000_0080);
        access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF_7F01);
        check("lh_be", 32'(b_be), 32'hC);
        check("lh_data", rdata_o, 32'hFFFF_80FF);
        access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 1, 32'h80FF_7F01);
        check("lhu_be", 32'(b_be), 32'h3);
        check("lhu_data", rdata_o, 32'h0000_7F01);

        access(1'b0, 1'b1, 3'b000, 32'h202, 32'h1234_5678, 1, 32'hFFFF_FFFF);
        check("sb_be", 32'(b_be), 32'h4);
        check("sb_wdata", b_wdata, 32'h7878_7878);
        check("sb_addr", b_addr, 32'h200);
        check("sb_we", 32'(b_we), 32'h1);
        check("sb_result", rdata_o, 32'h0);
        access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_5678, 1, 32'hFFFF_FFFF);
        check("sh_be", 32'(b_be), 32'hC);
        check("sh_wdata", b_wdata, 32'h5678_5678);
        access(1'b0, 1'b1, 3'b010, 32'h204, 32'h1234_5678, 2, 32'hFFFF_FFFF);
        check("sw_be", 32'(b_be), 32'hF);
        check("sw_wdata", b_wdata, 32'h1234_5678);
        check("sw_addr", b_addr, 32'h204);
        check("sw_stall", ns, 3);

        // Read and write together behave as a load
        access(1'b1, 1'b1, 3'b010, 32'h208, 32'hAAAA_5555, 1, 32'h0102_0304);
        check("rw_we", 32'(b_we), 32'h0);
        check("rw_data", rdata_o, 32'h0102_0304);

        fault_case("lw_mis", 3'b010, 32'h101);
        fault_case("lh_mis", 3'b001, 32'h103);
        fault_case("f3_ill", 3'b011, 32'h100);

        access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h0);
        check("to_stall", ns, 5);
        check("to_req", nr, 4);
        check("to_buserr", 32'(bus_err_o), 32'h1);
        check("to_regwrite", 32'(regwrite_o), 32'h0);
        check("to_data", rdata_o, 32'h0);
        check("to_req_done", 32'(dbus.req), 32'h0);

        access(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 2, 32'h1122_3344);
        check("after_to_stall", ns, 3);
        check("after_to_data", rdata_o, 32'h1122_3344);
        check("after_to_buserr", 32'(bus_err_o), 32'h0);
        check("after_to_regwrite", 32'(regwrite_o), 32'h1);

        // Ack arriving in the final timeout cycle wins
        access(1'b1, 1'b0, 3'b010, 32'h308, 32'h0, 4, 32'h5566_7788);
        check("edge_stall", ns, 5);
        check("edge_buserr", 32'(bus_err_o), 32'h0);
        check("edge_data", rdata_o, 32'h5566_7788);

        tick();
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu = 32'h400;
        tick();
        check("mid_req_busy", 32'(dbus.req), 32'h1);
        #2;
        rst = 1'b1;
        mem_read = 1'b0;
        #1;
        check("mid_req_drop", 32'(dbus.req), 32'h0);
        check("mid_addr", dbus.addr, 32'h0);
        check("mid_data", rdata_o, 32'h0);
        check("mid_stall", 32'(stall_o), 32'h0);
        tick();
        rst = 1'b0;
        dbus.ack = 1'b1;
        dbus.rdata = 32'hFFFF_FFFF;
        tick();
        dbus.ack = 1'b0;
        check("late_ack_req", 32'(dbus.req), 32'h0);
        check("late_ack_stall", 32'(stall_o), 32'h0);
        check("late_ack_buserr", 32'(bus_err_o), 32'h0);
        check("late_ack_data", rdata_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation did not finish");
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access (MEM) pipeline stage between `ex_mem` and `mem_wb`. It turns load/store control from `ex_mem` into word-aligned requests on a req/ack data bus with byte enables. It aligns and extends load data, and stalls the pipeline until the bus acknowledges. ALU result, write address and writeback controls pass through to `mem_wb`; `RegWrite` is suppressed when an access faults.

## Interface
- `ACK_TIMEOUT`, 255: maximum number of BUSY cycles without `dbus_ack_i` before the access aborts. Range 1..255; 8-bit counter.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset. One clock domain only.
- `ctrl_mem_MemRead_i` / `ctrl_mem_MemWrite_i` in 1 each: load / store request. Both high is treated as a load.
- `ctrl_mem_funct3_i` in 3: access size and sign. 000 B, 001 H, 010 W, 100 BU, 101 HU; any other value is illegal.
- `ctrl_wb_RegWrite_i`, `ctrl_wb_Mem2Reg_i` in 1 each: writeback controls.
- `alu_result_i` in 32: effective address, or result for non-memory instructions.
- `store_data_i` in 32: rs2 value.
- `write_addr_i` in 5: destination register.
- `ctrl_wb_RegWrite_o`, `ctrl_wb_Mem2Reg_o`, `alu_result_o`, `write_addr_o` out: to `mem_wb`.
- `mem_read_data_o` out 32: aligned, extended load data.
- `stall_o` out 1: hold PC, `if_id`, `id_ex` and `ex_mem`; `mem_wb` must not capture.
- `fault_o` out 1: misaligned address or illegal `funct3`.
- `bus_err_o` out 1: timeout abort.
- `dbus_req_o` out 1, `dbus_we_o` out 1, `dbus_addr_o` out 32 (bits [1:0] = 0), `dbus_wdata_o` out 32, `dbus_be_o` out 4.
- `dbus_ack_i` in 1, `dbus_rdata_i` in 32.

## Operation
- **Access.** `acc = MemRead | MemWrite`.
- **Alignment.** H requires `addr[0]=0`. W requires `addr[1:0]=0`. B is always aligned.
- **Byte enables.** B: `0001<<addr[1:0]`. H: `0011<<addr[1:0]`. W: `1111`.
- **Store data.** B replicates `store_data_i[7:0]` into all four bytes. H replicates `[15:0]` into both halves. W passes the word unchanged.
- **Load extraction.** Take the byte or half at `addr[1:0]*8`. Sign-extend for B/H; zero-extend for BU/HU. Both B and H are checked before extraction.
- **FSM states: IDLE, BUSY, DONE.**
- **IDLE:**
  - No `acc`: `stall_o=0`; all passthroughs are combinational from the inputs.
  - `acc` with a fault (misaligned or illegal `funct3`): `fault_o=1` combinationally, `ctrl_wb_RegWrite_o=0`, no bus request, no stall; stay in IDLE.
  - `acc` and legal: `stall_o=1` combinationally. On the clock edge, latch `addr&~3`, `we`, `be`, `wdata` and `funct3`/`addr[1:0]` into request registers; clear the timeout counter; go to BUSY.
- **BUSY:**
  - `dbus_req_o=1`, with request registers driven and held stable. `stall_o=1`.
  - Counter increments each cycle.
  - `dbus_ack_i=1`: capture the extracted rdata (stores capture 0) into the result register, clear the error flag, go to DONE.
  - Counter reaches `ACK_TIMEOUT` without ack: set the error flag, result=0, go to DONE; `dbus_req_o` deasserts from the next cycle.
- **DONE:**
  - `stall_o=0`, `mem_read_data_o` = result register; `mem_wb` captures on this edge.
  - If the error flag is set: `bus_err_o=1` and `ctrl_wb_RegWrite_o=0`.
  - Unconditionally go to IDLE. The instruction in `ex_mem` is consumed and is never re-issued.
- **Reset values** (asynchronous, take effect immediately): state IDLE; `dbus_req_o`, `dbus_we_o` = 0; `dbus_addr_o`, `dbus_wdata_o`, `dbus_be_o` = 0; result = 0; counter = 0; error flag = 0. Combinational outputs follow the inputs.

## Timing
- **Non-memory instruction:** zero added latency.
- **Load/store:** stall for 1 + N cycles, where N = cycles from BUSY entry to ack (N ≥ 1). DONE adds no stall cycle.
- **Earliest completion:** ack in the first BUSY cycle gives stall length 2; the instruction leaves on the following edge.
- **Bus rules:** `dbus_ack_i` is sampled only in BUSY and ignored elsewhere. Request registers are constant throughout BUSY; `dbus_req_o` never glitches. At most one request is outstanding.
- **Ack and timeout in the same cycle:** ack wins, no error.
- **Reset mid-BUSY:** `dbus_req_o` drops asynchronously. A late ack after reset is ignored.
- **`fault_o`, `bus_err_o`:** each is a single-cycle pulse.

## Test plan
- **Load word.** LW at `addr=0x100`; ack after 3 BUSY cycles with rdata `0xDEADBEEF`.
  - `dbus_addr_o=0x100`, `be=1111`, `we=0`.
  - `stall_o` high for 4 cycles.
  - DONE: `mem_read_data_o=0xDEADBEEF`, `RegWrite_o=1`.
- **Byte/half loads.** rdata `0x80FF7F01`:
  - LB `addr=0x103` → `0xFFFFFF80`.
  - LBU `addr=0x103` → `0x00000080`.
  - LH `addr=0x102` → `0xFFFF80FF`.
  - LHU `addr=0x100` → `0x00007F01`.
- **Stores.** `store_data_i=0x12345678`:
  - SB `addr=0x202` → `be=0100`, `wdata=0x78787878`, `addr=0x200`.
  - SH `addr=0x202` → `be=1100`, `wdata=0x56785678`.
  - SW → `be=1111`.
- **Misaligned and illegal.**
  - LW at `0x101`: `fault_o=1`, `RegWrite_o=0`, `dbus_req_o` stays 0, `stall_o=0`.
  - LH at `0x103`: same response.
  - `funct3=011`: same response.
- **Timeout.** `ACK_TIMEOUT=4`, no ack: `stall_o` high for 5 cycles, then `bus_err_o=1`, `RegWrite_o=0`, `mem_read_data_o=0`. A subsequent LW completes normally.
- **Reset mid-access.** Assert `rst` during BUSY, then ack one cycle later: `dbus_req_o=0` immediately, state is IDLE, no DONE, `mem_read_data_o=0`.
